// File: rtl/fifo_rd_burst_framer.sv
// fifo_rd_burst_framer: read side of the async FIFO in the r_clk domain.
// Prefetches FIFO words under a credit limit and absorbs the read latency in a
// small circular buffer. Re-emits the words as a valid/ready stream framed into
// BURST_LEN-beat bursts. A partial burst is closed after HOLD_CYCLES dry cycles.
module fifo_rd_burst_framer #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned SKID_DEPTH  = 4,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned HOLD_CYCLES = 64
) (
    input  logic                  r_clk,
    input  logic                  rrst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  rd_req,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  burst_done,
    output logic                  busy
);

    localparam int unsigned PTR_W  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned OCC_W  = $clog2(SKID_DEPTH + 1);
    localparam int unsigned INF_W  = $clog2(RD_LAT + 1);
    localparam int unsigned CRD_W  = $clog2(SKID_DEPTH + RD_LAT + 1);
    localparam int unsigned BEAT_W = $clog2(BURST_LEN);
    localparam int unsigned TMR_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    // Elaboration-time parameter sanity checks
    if (SKID_DEPTH < RD_LAT + 1) begin : g_chk_depth
        $error("SKID_DEPTH must be at least RD_LAT+1");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_chk_lat
        $error("RD_LAT must be in 1..4");
    end
    if (BURST_LEN < 2 || BURST_LEN > 256) begin : g_chk_burst
        $error("BURST_LEN must be in 2..256");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_chk_hold
        $error("HOLD_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_HOLD,
        ST_FLUSH
    } state_t;

    state_t                r_state;
    logic                  r_run;
    logic [RD_LAT-1:0]     r_pipe;
    logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [OCC_W-1:0]      r_occ;
    logic [BEAT_W-1:0]     r_beat_cnt;
    logic [TMR_W-1:0]      r_timer;
    logic                  r_burst_done;

    logic [INF_W-1:0]      w_inflight;
    logic                  w_wr;
    logic                  w_beat_last;
    logic                  w_sole;
    logic                  w_present;
    logic                  w_last;
    logic                  w_xfer;
    logic [OCC_W-1:0]      w_occ_nxt;
    logic                  w_credit;

    // Count reads in flight from the latency pipe
    always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + INF_W'(r_pipe[i]);
        end
    end

    // Head-of-buffer presentation and framing decisions
    always_comb begin
        w_wr        = r_pipe[RD_LAT-1];
        w_beat_last = (r_beat_cnt == BEAT_W'(BURST_LEN - 1));
        w_sole      = (r_occ == OCC_W'(1)) && (w_inflight == '0) && fifo_empty && !w_beat_last;
        w_present   = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_STREAM: begin
                w_present = (r_occ != '0) && !w_sole;
                w_last    = w_present && w_beat_last;
            end
            ST_FLUSH: begin
                w_present = (r_occ != '0);
                w_last    = w_present;
            end
            default: begin
                w_present = 1'b0;
                w_last    = 1'b0;
            end
        endcase
        w_xfer    = w_present && m_ready;
        w_occ_nxt = r_occ + OCC_W'(w_wr) - OCC_W'(w_xfer);
        w_credit  = (CRD_W'(r_occ) + CRD_W'(w_inflight)) < CRD_W'(SKID_DEPTH);
    end

    // Reads are gated off until the first clock after reset release
    assign rd_req     = r_run && !fifo_empty && w_credit;
    assign m_valid    = w_present;
    assign m_last     = w_last;
    assign m_data     = w_present ? r_mem[r_rd_ptr] : '0;
    assign burst_done = r_burst_done;
    assign busy       = (r_occ != '0) || (w_inflight != '0) || (r_beat_cnt != '0) ||
                        (r_state != ST_IDLE);

    // Read-enable, latency pipe, pointers and occupancy
    always_ff @(posedge r_clk or negedge rrst) begin
        if (!rrst) begin
            r_run    <= 1'b0;
            r_pipe   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            r_run  <= 1'b1;
            r_pipe <= RD_LAT'({r_pipe, rd_req});
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(SKID_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_xfer) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(SKID_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            r_occ <= w_occ_nxt;
        end
    end

    // Buffer storage; contents are don't-care until written
    always_ff @(posedge r_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= fifo_data;
        end
    end

    // Framing FSM with beat counter, hold timer and burst_done pulse
    always_ff @(posedge r_clk or negedge rrst) begin
        if (!rrst) begin
            r_state      <= ST_IDLE;
            r_beat_cnt   <= '0;
            r_timer      <= '0;
            r_burst_done <= 1'b0;
        end else begin
            r_burst_done <= w_xfer && w_last;
            case (r_state)
                ST_IDLE: begin
                    if (r_occ != '0) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        if (w_beat_last) begin
                            r_beat_cnt <= '0;
                            if (w_occ_nxt == '0) begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                        end
                    end else if (w_sole) begin
                        r_timer <= '0;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!fifo_empty || (w_inflight != '0)) begin
                        r_timer <= '0;
                        r_state <= ST_STREAM;
                    end else if (r_timer == TMR_W'(HOLD_CYCLES - 1)) begin
                        r_state <= ST_FLUSH;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (w_xfer) begin
                        r_beat_cnt <= '0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The credit limit must keep the buffer from ever overflowing
    a_no_overflow: assert property (@(posedge r_clk) disable iff (!rrst)
        !(w_wr && !w_xfer && (r_occ == OCC_W'(SKID_DEPTH))));

endmodule

// File: tb/tb_fifo_rd_burst_framer.sv
// Testbench for fifo_rd_burst_framer: behavioural FIFO with fixed read latency,
// scoreboard of expected (data, last) beats, and directed scenarios.
module tb_fifo_rd_burst_framer;

    localparam int unsigned DW          = 32;
    localparam int unsigned RD_LAT      = 2;
    localparam int unsigned SKID_DEPTH  = 4;
    localparam int unsigned BURST_LEN   = 16;
    localparam int unsigned HOLD_CYCLES = 64;
    localparam logic [DW-1:0] JUNK      = 32'hBADB_AD00;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk;
    logic          rrst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          rd_req;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;
    logic          burst_done;
    logic          busy;

    int            vectors;
    int            miscompares;
    exp_t          exp_q[$];
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] pipe_d [RD_LAT];
    bit            pipe_v [RD_LAT];
    bit            rd_req_s;
    int            sb_beat;
    bit            rdy_mode;
    int            rdy_ph;
    int            cyc;
    int            test_acc;
    int            first_acc_cyc;
    int            prev_acc_cyc;
    int            last_gap;
    int            bd_cnt;
    int            reads;
    int            accepts;
    int            max_outst;
    int            illegal_rd;
    bit            prev_stall;
    bit            prev_last_acc;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    fifo_rd_burst_framer #(
        .DATA_WIDTH (DW),
        .RD_LAT     (RD_LAT),
        .SKID_DEPTH (SKID_DEPTH),
        .BURST_LEN  (BURST_LEN),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .r_clk     (clk),
        .rrst      (rrst),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .rd_req    (rd_req),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .burst_done(burst_done),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Push words into the FIFO and their expected framing into the scoreboard
    task automatic send(input logic [DW-1:0] base, input int n, input bit flush_tail);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = base + DW'(i);
            e.last = (sb_beat == int'(BURST_LEN) - 1) || (flush_tail && (i == n - 1));
            exp_q.push_back(e);
            fifo_q.push_back(e.data);
            sb_beat = e.last ? 0 : sb_beat + 1;
        end
    endtask

    task automatic begin_test();
        test_acc      = 0;
        bd_cnt        = 0;
        last_gap      = 0;
        first_acc_cyc = 0;
        prev_acc_cyc  = 0;
        max_outst     = 0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 2000) begin
            step();
            n++;
        end
        chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
        repeat (4) step();
    endtask

    task automatic clear_models();
        fifo_q.delete();
        exp_q.delete();
        for (int i = 0; i < int'(RD_LAT); i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = JUNK;
        end
        rd_req_s   = 1'b0;
        sb_beat    = 0;
        fifo_empty = 1'b1;
        fifo_data  = JUNK;
        reads      = 0;
        accepts    = 0;
    endtask

    // FIFO model: pop on a sampled rd_req, deliver exactly RD_LAT cycles later
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
                pipe_d[i] = pipe_d[i-1];
                pipe_v[i] = pipe_v[i-1];
            end
            pipe_v[0] = 1'b0;
            pipe_d[0] = JUNK;
            if (rd_req_s && fifo_q.size() > 0) begin
                pipe_d[0] = fifo_q.pop_front();
                pipe_v[0] = 1'b1;
            end
            rd_req_s   = 1'b0;
            fifo_data  = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : JUNK;
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Downstream ready: always 1, or the 1,0,0,1 pattern
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) begin
                m_ready = (rdy_ph == 0) || (rdy_ph == 3);
                rdy_ph  = (rdy_ph + 1) % 4;
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    // Output monitor: scoreboard, stall stability, burst_done, credit tracking
    initial begin
        exp_t e;
        int   outst;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rrst) begin
                prev_stall    = 1'b0;
                prev_last_acc = 1'b0;
                rd_req_s      = 1'b0;
            end else begin
                outst = reads - accepts;
                if (outst > max_outst) max_outst = outst;
                if (rd_req && fifo_empty) illegal_rd++;
                rd_req_s = rd_req;
                if (rd_req) reads++;
                chk("burst_done", 64'(burst_done), 64'(prev_last_acc));
                if (burst_done) bd_cnt++;
                if (prev_stall) begin
                    chk("stall_valid", 64'(m_valid), 64'd1);
                    chk("stall_data", 64'(m_data), 64'(prev_data));
                    chk("stall_last", 64'(m_last), 64'(prev_last));
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("beat_unexpected_q_depth", 64'd0, 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", 64'(m_data), 64'(e.data));
                        chk("beat_last", 64'(m_last), 64'(e.last));
                    end
                    accepts++;
                    if (test_acc > 0) last_gap = cyc - prev_acc_cyc;
                    else first_acc_cyc = cyc;
                    prev_acc_cyc = cyc;
                    test_acc++;
                end
                prev_stall    = m_valid && !m_ready;
                prev_data     = m_data;
                prev_last     = m_last;
                prev_last_acc = m_valid && m_ready && m_last;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int infl;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        illegal_rd  = 0;
        rdy_mode    = 1'b0;
        rdy_ph      = 0;
        m_ready     = 1'b1;
        rrst        = 1'b0;
        clear_models();
        begin_test();
        repeat (3) step();

        // Reset state
        chk("rst_rd_req", 64'(rd_req), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_burst_done", 64'(burst_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rrst = 1'b1;
        repeat (3) step();

        // 1: two full bursts back to back
        begin_test();
        send(32'h0, 32, 1'b0);
        drain("t1");
        chk("t1_beats", 64'(test_acc), 64'd32);
        chk("t1_burst_done", 64'(bd_cnt), 64'd2);
        chk("t1_no_bubble", 64'(prev_acc_cyc - first_acc_cyc), 64'd31);
        chk("t1_busy", 64'(busy), 64'd0);

        // 2: partial burst closed by the hold timer
        begin_test();
        send(32'h100, 5, 1'b1);
        drain("t2");
        chk("t2_beats", 64'(test_acc), 64'd5);
        chk("t2_burst_done", 64'(bd_cnt), 64'd1);
        chk("t2_hold_gap", 64'((last_gap >= int'(HOLD_CYCLES)) && (last_gap <= int'(HOLD_CYCLES) + 4)), 64'd1);
        chk("t2_busy", 64'(busy), 64'd0);

        // 3: short gap resumes the burst without closing it
        begin_test();
        send(32'h200, 3, 1'b0);
        repeat (30) step();
        send(32'h203, 13, 1'b0);
        drain("t3");
        chk("t3_beats", 64'(test_acc), 64'd16);
        chk("t3_burst_done", 64'(bd_cnt), 64'd1);

        // 4: backpressure pattern 1,0,0,1
        rdy_mode = 1'b1;
        rdy_ph   = 0;
        begin_test();
        send(32'h300, 40, 1'b1);
        drain("t4");
        rdy_mode = 1'b0;
        chk("t4_beats", 64'(test_acc), 64'd40);
        chk("t4_burst_done", 64'(bd_cnt), 64'd3);
        chk("t4_credit", 64'(max_outst <= int'(SKID_DEPTH)), 64'd1);

        // 5: reset mid-burst with reads in flight
        begin_test();
        send(32'h400, 16, 1'b0);
        n = 0;
        while (test_acc < 7 && n < 200) begin
            step();
            n++;
        end
        chk("t5_seven_beats", 64'(test_acc), 64'd7);
        infl = 0;
        for (int i = 0; i < int'(RD_LAT); i++) infl += int'(pipe_v[i]);
        chk("t5_inflight", 64'(infl), 64'd2);
        rrst = 1'b0;
        #1;
        chk("t5_rd_req", 64'(rd_req), 64'd0);
        chk("t5_m_valid", 64'(m_valid), 64'd0);
        chk("t5_m_last", 64'(m_last), 64'd0);
        chk("t5_m_data", 64'(m_data), 64'd0);
        chk("t5_burst_done", 64'(burst_done), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        step();
        clear_models();
        repeat (3) step();
        rrst = 1'b1;
        step();
        begin_test();
        send(32'h500, 16, 1'b0);
        drain("t5");
        chk("t5_beats", 64'(test_acc), 64'd16);
        chk("t5_burst_done_after", 64'(bd_cnt), 64'd1);
        chk("t5_busy_end", 64'(busy), 64'd0);

        // 6: exactly one burst; last word goes out without a hold
        begin_test();
        send(32'h600, 16, 1'b0);
        drain("t6");
        chk("t6_beats", 64'(test_acc), 64'd16);
        chk("t6_burst_done", 64'(bd_cnt), 64'd1);
        chk("t6_last_gap", 64'(last_gap), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);

        chk("rd_req_while_empty", 64'(illegal_rd), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_rd_burst_framer.md
Name: fifo_rd_burst_framer

Overview:
Read-side stage directly downstream of the async FIFO, in the r_clk domain. Pulls words from the FIFO using rd_req/fifo_empty and absorbs the fixed FIFO read latency in a credit-controlled prefetch buffer. Re-emits the words as a valid/ready stream framed into bursts of BURST_LEN beats. A partial burst is closed after the FIFO has stayed dry for HOLD_CYCLES.

Parameters:
DATA_WIDTH, 32, word width; matches the FIFO data width.
RD_LAT, 2, cycles from a sampled rd_req to valid fifo_data; range 1..4.
SKID_DEPTH, 4, prefetch buffer entries; must be >= RD_LAT+1 (static check required).
BURST_LEN, 16, beats per full burst; range 2..256.
HOLD_CYCLES, 64, dry cycles before a partial burst is closed; range 1..65535.

Ports:
r_clk  input  1  read-domain clock; all logic on rising edge.
rrst  input  1  reset, asynchronous assert, active-low (0 = reset); deassertion synchronised upstream.
fifo_empty  input  1  FIFO empty flag; rd_req is legal only in a cycle where fifo_empty=0.
fifo_data  input  DATA_WIDTH  FIFO read data, valid exactly RD_LAT cycles after a cycle with rd_req=1.
rd_req  output  1  FIFO read request; one word per cycle high.
m_data  output  DATA_WIDTH  stream data.
m_valid  output  1  stream valid.
m_last  output  1  final beat of the current burst; qualified by m_valid.
m_ready  input  1  downstream accept.
burst_done  output  1  one-cycle pulse in the cycle after a beat with m_last=1 is accepted.
busy  output  1  high when the buffer is non-empty, reads are in flight, or a burst is partially sent.

Behaviour:
- Reset (rrst=0, asynchronous): rd_req=0, m_valid=0, m_last=0, m_data=0, burst_done=0, busy=0. Buffer is emptied, in-flight count, beat counter and hold timer are cleared, FSM goes to IDLE.
- Reset mid-operation: in-flight read data is discarded, and the partially sent burst is abandoned without an m_last.
- Credit rule:
  - rd_req = !fifo_empty && (occ + inflight) < SKID_DEPTH.
  - inflight is tracked by an RD_LAT-deep valid shift pipe.
  - A returning word is written into the buffer in the same cycle its pipe bit exits.
  - The buffer can never overflow. If it does, that is an assertion failure.
- The buffer is a circular buffer; pointers wrap at SKID_DEPTH. Simultaneous write and pop in one cycle leaves occ unchanged.
- Stream rules:
  - A beat transfers when m_valid && m_ready.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable and m_valid stays high.
  - m_data is the buffer head, which gives zero-bubble throughput of one beat per cycle at steady state.
- beat_cnt runs 0..BURST_LEN-1. It increments on each transfer and returns to 0 on any transfer with m_last=1.
- FSM states:
  - IDLE: buffer empty, beat_cnt=0, m_valid=0. Go to STREAM when occ>0.
  - STREAM:
    - The head is presented (m_valid=1) unless it is the sole remaining word: occ=1 && inflight=0 && fifo_empty=1 && beat_cnt!=BURST_LEN-1. In that case m_valid=0, the hold timer is cleared, and the FSM goes to HOLD.
    - m_last=1 when beat_cnt==BURST_LEN-1.
    - A transfer with m_last=1 goes to IDLE if occ becomes 0, otherwise stays in STREAM.
  - HOLD:
    - m_valid=0 and the timer increments each cycle.
    - If fifo_empty=0 or inflight>0, go back to STREAM and clear the timer.
    - When the timer reaches HOLD_CYCLES-1, go to FLUSH.
  - FLUSH: present the head with m_valid=1, m_last=1 and hold it until accepted. Then beat_cnt=0, burst_done pulses, and the FSM goes to IDLE.
- Once m_valid=1 is presented in FLUSH, m_last cannot be withdrawn. New FIFO arrivals during FLUSH only queue behind the head.
- A single-word burst is legal only through FLUSH.
- rd_req never depends on m_ready combinationally. Only m_valid/m_data/m_last are head-of-buffer combinational.

Test Plan:
1. Reset, write 32 words 0x0..0x1F into the FIFO, m_ready=1 throughout -> two bursts of 16, m_last on 0x0F and 0x1F, burst_done twice, no bubbles after the first beat, busy=0 at the end.
2. 5 words, then FIFO stays empty -> beats 0..3 stream with m_last=0. Word 4 is withheld for 64 cycles, then emitted with m_last=1, and burst_done pulses once.
3. 3 words, gap of 30 cycles, 13 more words -> no FLUSH; one 16-beat burst with m_last only on beat 15.
4. 40 words with m_ready toggling 1,0,0,1 repeatedly -> data order preserved, m_data/m_last stable while stalled, and occ+inflight never exceeds 4.
5. Assert rrst=0 mid-burst after 7 beats with 2 reads in flight -> all outputs are 0 within the same cycle. After release with 16 fresh words, exactly one burst is emitted with m_last on the 16th new word.
6. Exactly 16 words, fifo_empty rising after the 16th read -> word 15 is emitted immediately with m_last=1, the FSM does not enter HOLD, and the FSM returns to IDLE.
